// File: rtl/uart_cmd_parser.sv
// UART command frame parser: START/ID/CMD/VAL/CHK frames with XOR checksum and inter-byte timeout.
// Optional frame statistics counters are enabled with `define UART_CMD_PARSER_STATS_EN.
module uart_cmd_parser #(
  parameter logic [7:0] START_BYTE     = 8'hAA,
  parameter int         TIMEOUT_CYCLES = 500000,
  parameter int         CNT_W          = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  output logic        rdy_clr,
  output logic        cmd_valid,
  output logic [7:0]  dev_id,
  output logic [7:0]  cmd,
  output logic [7:0]  value,
  output logic        frame_err
`ifdef UART_CMD_PARSER_STATS_EN
  ,
  output logic [15:0] good_count,
  output logic [15:0] err_count
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_ID, S_CMD, S_VAL, S_CHK} state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_blk;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_acc, r_id, r_cmd, r_val;
  logic             w_accept, w_timeout, w_good, w_bad;

  // r_blk masks rx_rdy for two cycles so the receiver has time to drop it after rdy_clr
  assign w_accept  = rx_rdy && (r_blk == 2'd0);
  assign w_timeout = (r_state != S_IDLE) && !w_accept && (r_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_good      = 1'b0;
    w_bad       = 1'b0;
    if (w_accept) begin
      case (r_state)
        S_IDLE:  if (rx_data == START_BYTE) w_state_nxt = S_ID;
        S_ID:    w_state_nxt = S_CMD;
        S_CMD:   w_state_nxt = S_VAL;
        S_VAL:   w_state_nxt = S_CHK;
        S_CHK: begin
          w_good      = (rx_data == r_acc);
          w_bad       = (rx_data != r_acc);
          w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end else if (w_timeout) begin
      w_bad       = 1'b1;
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_clr   <= 1'b0;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      dev_id    <= 8'h00;
      cmd       <= 8'h00;
      value     <= 8'h00;
      r_blk     <= 2'd0;
      r_cnt     <= '0;
      r_acc     <= 8'h00;
      r_id      <= 8'h00;
      r_cmd     <= 8'h00;
      r_val     <= 8'h00;
    end else begin
      rdy_clr   <= w_accept;
      cmd_valid <= w_good;
      frame_err <= w_bad;
      if (w_accept)             r_blk <= 2'd2;
      else if (r_blk != 2'd0)   r_blk <= r_blk - 2'd1;
      // Counter idles at zero outside a frame and restarts on every accepted byte
      if (w_accept || w_timeout || (r_state == S_IDLE)) r_cnt <= '0;
      else                                              r_cnt <= r_cnt + 1'b1;
      if (w_accept) begin
        case (r_state)
          S_ID:  begin r_id  <= rx_data; r_acc <= rx_data;         end
          S_CMD: begin r_cmd <= rx_data; r_acc <= r_acc ^ rx_data; end
          S_VAL: begin r_val <= rx_data; r_acc <= r_acc ^ rx_data; end
          default: ;
        endcase
      end
      if (w_good) begin
        dev_id <= r_id;
        cmd    <= r_cmd;
        value  <= r_val;
      end
    end
  end

`ifdef UART_CMD_PARSER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_count <= 16'h0000;
      err_count  <= 16'h0000;
    end else begin
      if (cmd_valid && (good_count != 16'hFFFF)) good_count <= good_count + 16'h0001;
      if (frame_err && (err_count  != 16'hFFFF)) err_count  <= err_count  + 16'h0001;
    end
  end
`endif

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Consumes bytes from the UART receiver (data + level-sensitive ready) and clears its ready flag through `rdy_clr`.
- Assembles fixed 5-byte command frames: START, ID, CMD, VAL, CHK.
- Validates each frame with an XOR checksum and presents decoded commands to the main control logic as a one-cycle `cmd_valid` strobe.
- Sits between the receiver and main control; enforces an inter-byte timeout so a partial frame cannot stall the link.

Parameters:
- START_BYTE, 8'hAA, frame sync byte, recognised only in IDLE.
- TIMEOUT_CYCLES, 500000, max clk cycles allowed between accepted bytes inside a frame (≈10 byte times at 9600 baud, 50 MHz).
- CNT_W, 20, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte from UART receiver
- rx_rdy  in  1  receiver data-ready level
- rdy_clr  out  1  one-cycle pulse clearing receiver ready
- cmd_valid  out  1  one-cycle strobe: good frame decoded
- dev_id  out  8  ID field of last good frame
- cmd  out  8  CMD field of last good frame
- value  out  8  VAL field of last good frame
- frame_err  out  1  one-cycle strobe: checksum failure or timeout

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0, accumulator 0, block counter 0.
- Reset is asynchronous; assertion mid-frame discards the partial frame with no strobe.
- Byte acceptance:
  - A byte is accepted on a clk edge where rx_rdy=1 and block=0.
  - rdy_clr=1 in the following cycle only.
  - block stays set for 2 cycles after acceptance, covering the receiver's clear latency, so one rx_rdy assertion is never accepted twice.
- States:
  - IDLE: accepted byte == START_BYTE → ID; any other byte is dropped and state stays IDLE. Timeout counter is inactive.
  - ID: latch byte into id_r, acc = byte → CMD.
  - CMD: latch cmd_r, acc ^= byte → VAL.
  - VAL: latch val_r, acc ^= byte → CHK.
  - CHK, byte == acc:
    - next cycle: cmd_valid=1; dev_id/cmd/value update in that same cycle.
    - → IDLE.
  - CHK, byte != acc: next cycle frame_err=1; dev_id/cmd/value unchanged; → IDLE.
- START_BYTE received in ID/CMD/VAL/CHK is ordinary data; there is no mid-frame resync.
- Latency: cmd_valid asserts exactly 1 cycle after the CHK byte is accepted.
- dev_id/cmd/value hold their value until the next good frame.
- Timeout:
  - The counter clears on every accepted byte and increments each cycle while state ≠ IDLE.
  - When it reaches TIMEOUT_CYCLES-1: frame_err=1 for one cycle, → IDLE, counter clears.
  - Byte acceptance and timeout expiry in the same cycle: the byte wins and the counter clears; no error.
- cmd_valid and frame_err are never high in the same cycle.
- Checksum arithmetic: 8-bit XOR of ID, CMD and VAL; no carries.

Optional Feature:
- Macro: UART_CMD_PARSER_STATS_EN.
- Defined:
  - Adds output ports `good_count` (16) and `err_count` (16).
  - good_count increments on each cmd_valid; err_count increments on each frame_err.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Frame AA 01 10 FF EE (EE = 01^10^FF) with rx_rdy held until rdy_clr → exactly 5 rdy_clr pulses; cmd_valid=1 for one cycle, 1 cycle after the 5th acceptance; dev_id=01, cmd=10, value=FF; frame_err stays 0.
- Frame AA 01 10 FF 00 → frame_err=1 for one cycle; cmd_valid=0; dev_id/cmd/value keep their prior values.
- Junk 55 13 then AA 02 20 01 23 → 55 and 13 dropped in IDLE, each still producing a rdy_clr pulse; cmd_valid with dev_id=02, cmd=20, value=01.
- AA 03 then silence with TIMEOUT_CYCLES=100 → frame_err pulse 100 cycles after byte 03 is accepted; the following frame AA 04 40 00 44 decodes correctly.
- rst_n pulled low after AA 05 30 → all outputs 0 immediately; the next full frame AA 05 30 07 32 decodes with cmd_valid=1.
- With UART_CMD_PARSER_STATS_EN: 3 good frames + 2 bad frames → good_count=3, err_count=2.
